// File: rtl/sym_lock_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : sym_lock_fsm (with eq2 helper)
//  Purpose  : Four-symbol sequence lock with failed-attempt counting and timed
//             lockout. Symbol matching goes through the eq2 comparator.
//  Revision : 1.0  initial release
// ============================================================================

module eq2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       aeqb
);
    assign aeqb = ~(a[1] ^ b[1]) & ~(a[0] ^ b[0]);
endmodule

module sym_lock_fsm #(
    parameter logic [7:0] KEY            = 8'b10_01_11_00,
    parameter int         MAX_FAIL       = 3,
    parameter int         LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sym_valid,
    input  logic [1:0] sym,
    input  logic       clear,
    output logic       unlock,
    output logic       locked_out,
    output logic [2:0] progress,
    output logic [3:0] fail_cnt
);

    localparam logic [3:0] c_max_fail  = 4'(MAX_FAIL);
    localparam logic [7:0] c_lock_load = 8'(LOCKOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_P0   = 3'd0,
        S_P1   = 3'd1,
        S_P2   = 3'd2,
        S_P3   = 3'd3,
        S_LOCK = 3'd4
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_fail_cnt, w_fail_nxt, w_fail_inc;
    logic [7:0] r_lock_cnt, w_lock_cnt_nxt;
    logic       r_unlock, w_unlock_nxt;
    logic       r_locked_out, w_locked_out_nxt;
    logic [2:0] r_progress, w_progress_nxt;
    logic [1:0] w_exp;
    logic       w_match;

    // LOCK presents the first key symbol, matching its progress of 0.
    always_comb begin
        w_exp = KEY[7:6];
        case (r_state)
            S_P1:    w_exp = KEY[5:4];
            S_P2:    w_exp = KEY[3:2];
            S_P3:    w_exp = KEY[1:0];
            default: w_exp = KEY[7:6];
        endcase
    end

    eq2 u_eq2 (
        .a    (sym),
        .b    (w_exp),
        .aeqb (w_match)
    );

    assign w_fail_inc = r_fail_cnt + 4'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_fail_nxt     = r_fail_cnt;
        w_lock_cnt_nxt = r_lock_cnt;
        w_unlock_nxt   = 1'b0;
        if (clear) begin
            w_state_nxt    = S_P0;
            w_fail_nxt     = 4'd0;
            w_lock_cnt_nxt = 8'd0;
        end else if (r_state == S_LOCK) begin
            if (r_lock_cnt == 8'd0) begin
                w_state_nxt = S_P0;
                w_fail_nxt  = 4'd0;
            end else begin
                w_lock_cnt_nxt = r_lock_cnt - 8'd1;
            end
        end else if (sym_valid) begin
            if (w_match) begin
                case (r_state)
                    S_P0: w_state_nxt = S_P1;
                    S_P1: w_state_nxt = S_P2;
                    S_P2: w_state_nxt = S_P3;
                    default: begin
                        w_state_nxt  = S_P0;
                        w_unlock_nxt = 1'b1;
                        w_fail_nxt   = 4'd0;
                    end
                endcase
            end else begin
                // A mismatch restarts the attempt; the symbol itself is dropped.
                w_fail_nxt = w_fail_inc;
                if (w_fail_inc == c_max_fail) begin
                    w_state_nxt    = S_LOCK;
                    w_lock_cnt_nxt = c_lock_load;
                end else begin
                    w_state_nxt = S_P0;
                end
            end
        end
    end

    always_comb begin
        w_locked_out_nxt = (w_state_nxt == S_LOCK);
        w_progress_nxt   = w_locked_out_nxt ? 3'd0 : w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_P0;
            r_fail_cnt   <= 4'd0;
            r_lock_cnt   <= 8'd0;
            r_unlock     <= 1'b0;
            r_locked_out <= 1'b0;
            r_progress   <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_fail_cnt   <= w_fail_nxt;
            r_lock_cnt   <= w_lock_cnt_nxt;
            r_unlock     <= w_unlock_nxt;
            r_locked_out <= w_locked_out_nxt;
            r_progress   <= w_progress_nxt;
        end
    end

    assign unlock     = r_unlock;
    assign locked_out = r_locked_out;
    assign progress   = r_progress;
    assign fail_cnt   = r_fail_cnt;

endmodule

`default_nettype wire
